// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : shares the program/data memory between the CPU and a
//                   debug/loader port, stealing the bus at instruction edges
// Revision        : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cpu_phase,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wr,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_hold,
  input  logic                  dbg_req,
  input  logic                  dbg_wr,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [15:0]           dbg_wdata,
  output logic                  dbg_ack,
  output logic [15:0]           dbg_rdata,
  output logic                  dbg_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_DATA    = 3'd2,
    S_ACKW    = 3'd3,
    S_RESTORE = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        hold_q, hold_d;
  logic        ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic [3:0]  count_q, count_d;
  logic        turn_q, turn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 16'h0000;
      count_q <= 4'd0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    count_d = count_q;
    turn_d  = turn_q;

    // Phase 1 means the CPU has fetched and started a full instruction.
    if (cpu_phase == 2'd1) begin
      turn_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Granting in phase 2 lets the registered hold catch the first phase-3 cycle.
        if (dbg_req && (cpu_phase == 2'd2) && !turn_q) begin
          state_d = S_ACCESS;
          hold_d  = 1'b1;
          count_d = 4'd0;
        end
      end
      S_ACCESS: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        rdata_d = mem_rdata;
        ack_d   = 1'b1;
        count_d = count_q + 4'd1;
        state_d = S_ACKW;
      end
      S_ACKW: begin
        ack_d = 1'b0;
        if (dbg_req && (count_q < C_MAX_BURST)) begin
          state_d = S_ACCESS;
        end else begin
          state_d = S_RESTORE;
        end
      end
      S_RESTORE: begin
        hold_d  = 1'b0;
        turn_d  = 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wr    = cpu_wr;
    mem_wdata = cpu_wdata;
    case (state_q)
      S_ACCESS: begin
        mem_addr  = dbg_addr;
        mem_wr    = dbg_wr;
        mem_wdata = dbg_wdata;
      end
      S_DATA, S_ACKW: begin
        mem_addr  = dbg_addr;
        mem_wr    = 1'b0;
        mem_wdata = dbg_wdata;
      end
      default: begin
        mem_addr  = cpu_addr;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_wdata;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_hold  = hold_q;
  assign dbg_ack   = ack_q;
  assign dbg_rdata = rdata_q;
  assign dbg_busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire
